// File: rtl/sdram_init_ref_if.sv
// sdram_init_ref_if: SDRAM command bus plus refresh handshake between sequencer and arbiter
interface sdram_init_ref_if #(
  parameter int ADDR_W = 12,
  parameter int BA_W = 2
);
  logic [3:0] sdram_cmd;
  logic [BA_W-1:0] sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  logic init_done;
  logic ref_req;
  logic ref_en;
  logic ref_done;
  logic ref_overdue;
  modport master (
    output sdram_cmd, sdram_ba, sdram_addr, init_done, ref_req, ref_done, ref_overdue,
    input ref_en
  );
  modport slave (
    input sdram_cmd, sdram_ba, sdram_addr, init_done, ref_req, ref_done, ref_overdue,
    output ref_en
  );
endinterface

// File: rtl/sdram_init_ref.sv
// sdram_init_ref: SDRAM power-up initialisation and periodic auto-refresh sequencer
module sdram_init_ref #(
  parameter int ADDR_W = 12,
  parameter int BA_W = 2,
  parameter int T_POWERUP = 20000,
  parameter int T_RP = 2,
  parameter int T_RFC = 7,
  parameter int T_MRD = 2,
  parameter int INIT_REFRESHES = 8,
  parameter int REF_INTERVAL = 1562,
  parameter int CAS_LAT = 3,
  parameter logic [2:0] BL_CODE = 3'b111
) (
  input logic sclk,
  input logic rst,
  sdram_init_ref_if.master bus
);
  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;
  localparam int CW = $clog2(T_POWERUP + T_RP + T_RFC + T_MRD + 2);
  localparam int RW = $clog2(REF_INTERVAL + 1);
  localparam int NW = $clog2(INIT_REFRESHES + 1);
  localparam logic [ADDR_W-1:0] A10 = ADDR_W'(1) << 10;
  localparam logic [ADDR_W-1:0] MODE = ADDR_W'({3'(CAS_LAT), 1'b0, BL_CODE});
  // Each wait state issues the next command on the edge that ends it, so a
  // command lands on the bus in the cycle the previous wait expires.
  typedef enum logic [2:0] {S_WAIT, S_TRP, S_TRFC, S_TMRD, S_IDLE, R_TRP, R_TRFC} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [NW-1:0] nref;
  logic [RW-1:0] rtmr;
  logic wrap;
  logic start;
  assign wrap = bus.init_done && rtmr == RW'(REF_INTERVAL - 1);
  assign start = state == S_IDLE && bus.ref_req && bus.ref_en;
  // Sequencer FSM, refresh timer and all registered outputs
  always_ff @(posedge sclk or posedge rst)
    if (rst) begin
      state <= S_WAIT;
      cnt <= '0;
      nref <= '0;
      rtmr <= '0;
      bus.sdram_cmd <= NOP;
      bus.sdram_addr <= '0;
      bus.sdram_ba <= '0;
      bus.init_done <= 1'b0;
      bus.ref_req <= 1'b0;
      bus.ref_done <= 1'b0;
      bus.ref_overdue <= 1'b0;
    end else begin
      bus.sdram_cmd <= NOP;
      bus.sdram_addr <= '0;
      bus.sdram_ba <= '0;
      bus.ref_done <= 1'b0;
      cnt <= cnt + CW'(1);
      if (bus.init_done) rtmr <= wrap ? '0 : rtmr + RW'(1);
      bus.ref_req <= wrap || (bus.ref_req && !start);
      if (wrap && bus.ref_req && !start) bus.ref_overdue <= 1'b1;
      case (state)
        S_WAIT:
          if (cnt == CW'(T_POWERUP)) begin
            bus.sdram_cmd <= PRE;
            bus.sdram_addr <= A10;
            cnt <= '0;
            state <= S_TRP;
          end
        S_TRP:
          if (cnt == CW'(T_RP - 1)) begin
            bus.sdram_cmd <= AREF;
            nref <= nref + NW'(1);
            cnt <= '0;
            state <= S_TRFC;
          end
        S_TRFC:
          if (cnt == CW'(T_RFC - 1)) begin
            cnt <= '0;
            if (nref == NW'(INIT_REFRESHES)) begin
              bus.sdram_cmd <= MRS;
              bus.sdram_addr <= MODE;
              state <= S_TMRD;
            end else begin
              bus.sdram_cmd <= AREF;
              nref <= nref + NW'(1);
            end
          end
        S_TMRD:
          if (cnt == CW'(T_MRD - 1)) begin
            bus.init_done <= 1'b1;
            state <= S_IDLE;
          end
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            bus.sdram_cmd <= PRE;
            bus.sdram_addr <= A10;
            state <= R_TRP;
          end
        end
        R_TRP:
          if (cnt == CW'(T_RP - 1)) begin
            bus.sdram_cmd <= AREF;
            cnt <= '0;
            state <= R_TRFC;
          end
        R_TRFC:
          if (cnt == CW'(T_RFC - 1)) begin
            bus.ref_done <= 1'b1;
            state <= S_IDLE;
          end
        default: state <= S_WAIT;
      endcase
    end
endmodule

// File: tb/tb_sdram_init_ref.sv
// tb_sdram_init_ref: table-driven and randomized checks of the init/refresh sequencer against a timeline model
module tb_sdram_init_ref;
  localparam int T_PU = 10;
  localparam int T_RP = 2;
  localparam int T_RFC = 7;
  localparam int T_MRD = 2;
  localparam int NREF = 2;
  localparam int RI = 50;
  localparam int P = T_PU;
  localparam int M = P + T_RP + NREF * T_RFC;
  localparam int I = M + T_MRD;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_AREF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;
  typedef struct {
    int cyc;
    logic [3:0] cmd;
    logic [11:0] addr;
    logic init;
    logic req;
    logic done;
  } vec_t;
  logic sclk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  int c = -1;
  int pre_at = -1000;
  bit mreq = 0;
  bit movd = 0;
  logic en_e;
  logic [21:0] cap [0:99];
  logic [21:0] cap2 [0:99];
  vec_t tbl [$];
  vec_t tbl2 [$];
  always #5 sclk = ~sclk;
  sdram_init_ref_if #(.ADDR_W(12), .BA_W(2)) b1 ();
  sdram_init_ref_if #(.ADDR_W(12), .BA_W(2)) b2 ();
  sdram_init_ref #(
    .ADDR_W(12), .BA_W(2), .T_POWERUP(T_PU), .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD),
    .INIT_REFRESHES(NREF), .REF_INTERVAL(RI), .CAS_LAT(3), .BL_CODE(3'b111)
  ) dut (.sclk(sclk), .rst(rst), .bus(b1));
  sdram_init_ref #(
    .ADDR_W(12), .BA_W(2), .T_POWERUP(T_PU), .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD),
    .INIT_REFRESHES(8), .REF_INTERVAL(RI), .CAS_LAT(2), .BL_CODE(3'b011)
  ) dut2 (.sclk(sclk), .rst(rst), .bus(b2));
  function automatic logic [21:0] obs1();
    return {b1.sdram_cmd, b1.sdram_ba, b1.sdram_addr, b1.init_done, b1.ref_req, b1.ref_done, b1.ref_overdue};
  endfunction
  function automatic logic [21:0] obs2();
    return {b2.sdram_cmd, b2.sdram_ba, b2.sdram_addr, b2.init_done, b2.ref_req, b2.ref_done, b2.ref_overdue};
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, c, a, e);
    end
  endtask
  // Timeline model: request/grant bookkeeping at edge c
  task automatic model_edge(input logic en);
    bit idle_prev;
    bit st;
    bit wr;
    idle_prev = (c - 1 >= I) && (c - 1 >= pre_at + T_RP + T_RFC);
    st = idle_prev && mreq && (en === 1'b1);
    wr = c > I && (c - I) % RI == 0;
    if (st) pre_at = c;
    if (wr && mreq && !st) movd = 1;
    mreq = wr || (mreq && !st);
  endtask
  function automatic logic [21:0] expect_cur();
    logic [3:0] cmd;
    logic [11:0] addr;
    bit done;
    cmd = C_NOP;
    addr = 12'h0;
    if (c == P) begin cmd = C_PRE; addr = 12'h400; end
    for (int k = 0; k < NREF; k++) if (c == P + T_RP + k * T_RFC) cmd = C_AREF;
    if (c == M) begin cmd = C_MRS; addr = 12'h037; end
    if (pre_at >= I && c == pre_at) begin cmd = C_PRE; addr = 12'h400; end
    if (pre_at >= I && c == pre_at + T_RP) cmd = C_AREF;
    done = pre_at >= I && c == pre_at + T_RP + T_RFC;
    return {cmd, 2'b00, addr, c >= I, mreq, done, movd};
  endfunction
  task automatic step();
    en_e = b1.ref_en;
    @(posedge sclk);
    #1;
    c++;
    model_edge(en_e);
    chk("cycle", obs1(), expect_cur());
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("reset", obs1(), {C_NOP, 18'h0});
    chk("reset2", obs2(), {C_NOP, 18'h0});
    @(negedge sclk);
    rst = 1'b0;
    c = -1;
    pre_at = -1000;
    mreq = 0;
    movd = 0;
  endtask
  initial begin
    tbl.push_back('{9, C_NOP, 12'h000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{10, C_PRE, 12'h400, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{11, C_NOP, 12'h000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{12, C_AREF, 12'h000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{19, C_AREF, 12'h000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{26, C_MRS, 12'h037, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{27, C_NOP, 12'h000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{28, C_NOP, 12'h000, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{77, C_NOP, 12'h000, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{78, C_NOP, 12'h000, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{79, C_PRE, 12'h400, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{81, C_AREF, 12'h000, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{87, C_NOP, 12'h000, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{88, C_NOP, 12'h000, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{89, C_NOP, 12'h000, 1'b1, 1'b0, 1'b0});
    tbl2.push_back('{67, C_NOP, 12'h000, 1'b0, 1'b0, 1'b0});
    tbl2.push_back('{68, C_MRS, 12'h023, 1'b0, 1'b0, 1'b0});
    tbl2.push_back('{69, C_NOP, 12'h000, 1'b0, 1'b0, 1'b0});
    tbl2.push_back('{70, C_NOP, 12'h000, 1'b1, 1'b0, 1'b0});
    b1.ref_en = 1'b0;
    b2.ref_en = 1'b0;
    @(posedge sclk);
    #1;
    do_reset();
    // grant held high throughout: covers init-time grants and the immediate refresh
    b1.ref_en = 1'b1;
    while (c < 95) begin
      step();
      if (c >= 0 && c < 100) begin
        cap[c] = obs1();
        cap2[c] = obs2();
      end
    end
    foreach (tbl[i])
      chk($sformatf("tbl_c%0d", tbl[i].cyc),
          {cap[tbl[i].cyc][21:18], cap[tbl[i].cyc][15:4], cap[tbl[i].cyc][3:1]},
          {tbl[i].cmd, tbl[i].addr, tbl[i].init, tbl[i].req, tbl[i].done});
    foreach (tbl2[i])
      chk($sformatf("sweep_c%0d", tbl2[i].cyc),
          {cap2[tbl2[i].cyc][21:18], cap2[tbl2[i].cyc][15:4], cap2[tbl2[i].cyc][3]},
          {tbl2[i].cmd, tbl2[i].addr, tbl2[i].init});
    // delayed grant: overdue at 128, then random grants with a sticky overdue flag
    do_reset();
    b1.ref_en = 1'b0;
    while (c < 450) begin
      step();
      if (c == 127) chk("ovd_before", b1.ref_overdue, 1'b0);
      if (c == 128) chk("ovd_set", {b1.ref_req, b1.ref_overdue}, 2'b11);
      if (c >= 130) b1.ref_en = ($urandom_range(0, 3) == 0);
    end
    chk("ovd_sticky", b1.ref_overdue, 1'b1);
    // asynchronous reset clears overdue, then reset again during the refresh AREF
    do_reset();
    b1.ref_en = 1'b1;
    while (c < 81) step();
    chk("aref_at_81", b1.sdram_cmd, C_AREF);
    rst = 1'b1;
    #1;
    chk("async_reset", obs1(), {C_NOP, 18'h0});
    @(negedge sclk);
    rst = 1'b0;
    c = -1;
    pre_at = -1000;
    mreq = 0;
    movd = 0;
    while (c < 40) begin
      step();
      if (c == 10) chk("restart_pre", {b1.sdram_cmd, b1.sdram_addr}, {C_PRE, 12'h400});
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
